// File: rtl/fs4_serial_if.sv
// fs4_serial_if: start/ready/done handshake and operand/result bus for fs4_serial
`timescale 1ns/1ps
interface fs4_serial_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Zero;
  logic             Ovf;
  modport master (output start, A, B, Bin, input ready, done, Diff, Bout, Zero, Ovf);
  modport slave (input start, A, B, Bin, output ready, done, Diff, Bout, Zero, Ovf);
endinterface

// File: rtl/fs4_serial.sv
// fs4_serial: bit-serial subtractor computing A - B - Bin one bit per clock, LSB first
`timescale 1ns/1ps
module fs4_serial #(parameter int WIDTH = 4) (
  input logic        clk,
  input logic        rst_n,
  fs4_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_d, r_diff, w_dfin;
  logic [CW-1:0]    r_cnt;
  logic             r_brw, r_amsb, r_bmsb, r_bout, r_zero, r_ovf;
  logic             w_acc, w_last, w_d, w_brw;
  // one full-subtractor bit slice plus handshake decode and next state
  always_comb begin
    w_acc = bus.start && (r_state != SHIFT);
    w_last = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    w_d = r_a[0] ^ r_b[0] ^ r_brw;
    w_brw = (~r_a[0] & r_b[0]) | (~r_a[0] & r_brw) | (r_b[0] & r_brw);
    w_dfin = {w_d, r_d[WIDTH-1:1]};
    w_next = w_acc ? SHIFT : (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // operand capture and serial shift; result registers load only on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_d <= '0;
      r_brw <= 1'b0;
      r_cnt <= '0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_acc) begin
      r_a <= bus.A;
      r_b <= bus.B;
      r_brw <= bus.Bin;
      r_cnt <= '0;
      r_amsb <= bus.A[WIDTH-1];
      r_bmsb <= bus.B[WIDTH-1];
    end else if (r_state == SHIFT) begin
      r_a <= {1'b0, r_a[WIDTH-1:1]};
      r_b <= {1'b0, r_b[WIDTH-1:1]};
      r_d <= w_dfin;
      r_brw <= w_brw;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_dfin;
        r_bout <= w_brw;
        r_zero <= ~|w_dfin;
        r_ovf <= (r_amsb != r_bmsb) && (w_dfin[WIDTH-1] != r_amsb);
      end
    end
  end
  assign bus.ready = (r_state != SHIFT);
  assign bus.done = (r_state == DONE);
  assign bus.Diff = r_diff;
  assign bus.Bout = r_bout;
  assign bus.Zero = r_zero;
  assign bus.Ovf = r_ovf;
endmodule

// File: tb/tb_fs4_serial.sv
// tb_fs4_serial: directed and exhaustive scoreboard checks for fs4_serial
`timescale 1ns/1ps
module tb_fs4_serial;
  localparam int W = 4;
  typedef struct packed {logic [W-1:0] d; logic bo; logic z; logic o;} res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_tot = 0;
  logic [W-1:0] last_d = '0;
  res_t q[$];
  fs4_serial_if #(.WIDTH(W)) bus();
  fs4_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] t;
    res_t m;
    t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    m.d = t[W-1:0];
    m.bo = t[W];
    m.z = (m.d == '0);
    m.o = (a[W-1] != b[W-1]) && (m.d[W-1] != a[W-1]);
    return m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.A = a;
    bus.B = b;
    bus.Bin = bin;
    bus.start = 1'b1;
    chk("ready_at_start", 32'(bus.ready), 1);
    q.push_back(model(a, b, bin));
  endtask
  task automatic check_out(input string tag);
    res_t e;
    chk({tag, "_queue"}, 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      last_d = e.d;
      chk({tag, "_diff"}, 32'(bus.Diff), 32'(e.d));
      chk({tag, "_bout"}, 32'(bus.Bout), 32'(e.bo));
      chk({tag, "_zero"}, 32'(bus.Zero), 32'(e.z));
      chk({tag, "_ovf"}, 32'(bus.Ovf), 32'(e.o));
    end
  endtask
  task automatic wait_done(input string tag);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
    end while (!bus.done && lat < 20);
    chk({tag, "_latency"}, 32'(lat), W + 1);
    check_out(tag);
  endtask
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    issue(a, b, bin);
    wait_done(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 0);
    chk({tag, "_idle"}, 32'(bus.ready), 1);
  endtask
  initial begin
    int seen;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_diff", 32'(bus.Diff), 0);
    chk("rst_bout", 32'(bus.Bout), 0);
    chk("rst_zero", 32'(bus.Zero), 0);
    chk("rst_ovf", 32'(bus.Ovf), 0);
    rst_n = 1'b1;
    op("basic", 4'd9, 4'd3, 1'b0);
    op("underflow", 4'd3, 4'd9, 1'b0);
    op("bin_wrap", 4'd0, 4'd0, 1'b1);
    op("ovf", 4'h7, 4'hF, 1'b0);
    op("zero", 4'd5, 4'd5, 1'b0);
    @(negedge clk);
    issue(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 4'hF;
    bus.B = 4'h0;
    bus.Bin = 1'b1;
    chk("busy_ready", 32'(bus.ready), 0);
    chk("busy_hold_diff", 32'(bus.Diff), 32'(last_d));
    @(negedge clk);
    chk("busy_done", 32'(bus.done), 0);
    chk("busy_hold_zero", 32'(bus.Zero), 1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ignore_done", 32'(bus.done), 1);
    check_out("ignore");
    @(negedge clk);
    issue(4'd12, 4'd4, 1'b1);
    wait_done("b2b_first");
    issue(4'd2, 4'd6, 1'b0);
    wait_done("b2b_second");
    @(negedge clk);
    issue(4'hE, 4'h1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.ready), 1);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_diff", 32'(bus.Diff), 0);
    chk("abort_bout", 32'(bus.Bout), 0);
    chk("abort_zero", 32'(bus.Zero), 0);
    chk("abort_ovf", 32'(bus.Ovf), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);
    chk("abort_ready_after", 32'(bus.ready), 1);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op("sweep", W'(a), W'(b), c[0]);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
